mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder with fixed latency, byte strobes and fault/fetch tracking
// Requests are captured in IDLE and answered once; dropping mem_valid before the strobe aborts the access.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic        fault_q;
  logic [15:0] fetch_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] offset;
  logic [31:0] word_idx;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        resp_live;
  logic        do_write;
  logic [15:0] fetch_d;

  // Subtraction wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign offset    = addr_q - BASE_ADDR;
  assign word_idx  = offset >> 2;
  assign in_range  = (word_idx < DEPTH_WORDS);
  assign idx       = word_idx[AW-1:0];

  assign resp_live = (state_q == S_RESP) && mem_valid;
  assign do_write  = resp_live && in_range && (|wstrb_q);
  assign fetch_d   = fetch_q + 16'd1;

  assign mem_ready   = resp_live;
  assign mem_rdata   = (resp_live && in_range) ? mem_q[idx] : 32'h0;
  assign fault       = fault_q;
  assign fetch_count = fetch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      instr_q <= 1'b0;
      fault_q <= 1'b0;
      fetch_q <= 16'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
            cnt_q   <= LAT_M1;
            state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_valid) begin
            fault_q <= 1'b1;
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          if (!mem_valid || !in_range) begin
            fault_q <= 1'b1;
          end
          if (mem_valid && instr_q) begin
            fetch_q <= fetch_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at LATENCY 1 and LATENCY 4
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        vld   [2];
  logic        ins   [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [3:0]  ws    [2];
  logic        rdy   [2];
  logic [31:0] rdata [2];
  logic        flt   [2];
  logic [15:0] fc    [2];

  int   cyc;
  int   n_chk;
  int   n_fail;
  exp_t q0 [$];
  exp_t q1 [$];

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
    .clk(clk), .reset(rst), .mem_valid(vld[0]), .mem_instr(ins[0]),
    .mem_addr(addr[0]), .mem_wdata(wd[0]), .mem_wstrb(ws[0]),
    .mem_ready(rdy[0]), .mem_rdata(rdata[0]), .fault(flt[0]), .fetch_count(fc[0])
  );

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .BASE_ADDR(32'h0)) u_lat4 (
    .clk(clk), .reset(rst), .mem_valid(vld[1]), .mem_instr(ins[1]),
    .mem_addr(addr[1]), .mem_wdata(wd[1]), .mem_wstrb(ws[1]),
    .mem_ready(rdy[1]), .mem_rdata(rdata[1]), .fault(flt[1]), .fetch_count(fc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_port(input int d, input exp_t e, input bit have);
    if (!have) begin
      check($sformatf("unexpected_ready_d%0d", d), 32'd1, 32'd0);
    end else begin
      check($sformatf("ready_cycle_d%0d", d), cyc, e.cyc);
      if (e.chk) check($sformatf("rdata_d%0d", d), rdata[d], e.rdata);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rdy[0]) begin
        if (q0.size() > 0) begin e = q0.pop_front(); mon_port(0, e, 1'b1); end
        else mon_port(0, e, 1'b0);
      end else begin
        check("rdata_idle_d0", rdata[0], 32'h0);
      end
      if (rdy[1]) begin
        if (q1.size() > 0) begin e = q1.pop_front(); mon_port(1, e, 1'b1); end
        else mon_port(1, e, 1'b0);
      end else begin
        check("rdata_idle_d1", rdata[1], 32'h0);
      end
    end
  end

  // Issues one request; inputs are scrambled after acceptance to show the captured copy is used.
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                     input logic i, input logic [31:0] exp, input bit chk);
    int lat;
    exp_t e;
    lat = (d == 0) ? 1 : 4;
    vld[d] = 1'b1; addr[d] = a; wd[d] = w; ws[d] = s; ins[d] = i;
    e.rdata = exp; e.chk = chk; e.cyc = cyc + lat;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    addr[d] = 32'hFFFF_FFF0; wd[d] = ~w; ws[d] = ~s; ins[d] = ~i;
    repeat (lat) @(posedge clk);
    #1;
    vld[d] = 1'b0; addr[d] = 32'h0; wd[d] = 32'h0; ws[d] = 4'h0; ins[d] = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; ins[d] = 1'b0; addr[d] = 32'h0; wd[d] = 32'h0; ws[d] = 4'h0;
    end
    vld[0] = 1'b1;
    addr[0] = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    vld[0] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ready_d%0d", d), 32'(rdy[d]), 32'h0);
      check($sformatf("reset_rdata_d%0d", d), rdata[d], 32'h0);
      check($sformatf("reset_fault_d%0d", d), 32'(flt[d]), 32'h0);
      check($sformatf("reset_fetch_d%0d", d), 32'(fc[d]), 32'h0);
    end
    step(1);

    req(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0);
    req(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    req(0, 32'h10, 32'h0000_0055, 4'h1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    req(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BE55, 1'b1);
    req(0, 32'h13, 32'h0, 4'h0, 1'b0, 32'hDEAD_BE55, 1'b1);
    req(0, 32'h14, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0, 1'b0);
    req(0, 32'h14, 32'h1122_3344, 4'hA, 1'b0, 32'hA5A5_A5A5, 1'b1);
    req(0, 32'h14, 32'h0, 4'h0, 1'b0, 32'h11A5_33A5, 1'b1);
    req(0, 32'hFFC, 32'h0BAD_CAFE, 4'hF, 1'b0, 32'h0, 1'b0);
    req(0, 32'hFFC, 32'h0, 4'h0, 1'b0, 32'h0BAD_CAFE, 1'b1);
    req(0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BE55, 1'b1);
    check("fetch_after_one_d0", 32'(fc[0]), 32'd1);
    check("fault_clean_d0", 32'(flt[0]), 32'd0);
    req(0, 32'h1000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    check("fault_oor_read_d0", 32'(flt[0]), 32'd1);
    check("fetch_oor_d0", 32'(fc[0]), 32'd2);
    req(0, 32'h1000, 32'h7777_7777, 4'hF, 1'b0, 32'h0, 1'b0);
    req(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BE55, 1'b1);
    req(0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    step(3);
    check("fault_sticky_d0", 32'(flt[0]), 32'd1);

    req(1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0);
    req(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b1);
    req(1, 32'h20, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b1);
    check("fetch_one_d1", 32'(fc[1]), 32'd1);
    check("fault_clean_d1", 32'(flt[1]), 32'd0);

    vld[1] = 1'b1; addr[1] = 32'h20; wd[1] = 32'h1234_5678; ws[1] = 4'hF;
    step(2);
    vld[1] = 1'b0;
    step(1);
    check("fault_abort_d1", 32'(flt[1]), 32'd1);
    step(5);
    req(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b1);

    vld[1] = 1'b1; addr[1] = 32'h20; wd[1] = 32'hFFFF_FFFF; ws[1] = 4'hF;
    step(2);
    rst = 1'b1;
    vld[1] = 1'b0;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_fault_d1", 32'(flt[1]), 32'd0);
    check("rst_fetch_d1", 32'(fc[1]), 32'd0);
    check("rst_ready_d1", 32'(rdy[1]), 32'd0);
    check("rst_fault_d0", 32'(flt[0]), 32'd0);
    step(1);
    req(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b1);
    req(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BE55, 1'b1);
    for (int k = 0; k < 3; k++) req(1, 32'h20, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b1);
    check("fetch_three_d1", 32'(fc[1]), 32'd3);
    check("fault_after_rst_d1", 32'(flt[1]), 32'd0);

    step(6);
    check("pending_d0", q0.size(), 32'd0);
    check("pending_d1", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
